usb_event_ctrl: RTL and testbench
=================================

USB_EVENT_CTRL -- requirements
Module: usb_event_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops per input pin; legal range 2..3.
REQ-002 Parameter TIMEOUT_CYC, default 50000: service-timeout length in clk cycles (1 ms at 50 MHz); legal range 1..65535.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 address  in  2  Avalon-MM word address.
REQ-006 chipselect  in  1  Avalon-MM slave select.
REQ-007 write  in  1  Avalon-MM write strobe, qualified by chipselect.
REQ-008 writedata  in  32  Avalon-MM write data.
REQ-009 readdata  out  32  Avalon-MM read data, registered.
REQ-010 in_gpx  in  1  MAX3421E GPX pin, asynchronous to clk.
REQ-011 in_int  in  1  MAX3421E INT pin, active-high, asynchronous to clk.
REQ-012 irq  out  1  level interrupt to the CPU, registered.

Function
REQ-013 Each pin passes through SYNC_STAGES flops; edge detect compares the last sync stage with a one-flop delayed copy.
REQ-014 Edge latency: an input change is reflected in EDGE exactly SYNC_STAGES+1 cycles after the first clk edge that samples it.
REQ-015 Register map: 0 STATUS (RO): [0] gpx level, [1] int level, [2] timeout sticky flag, [4:3] FSM state code; 1 EDGE (W1C): [0] gpx rise, [1] gpx fall, [2] int rise; 2 MASK (RW) [2:0]; 3 COUNT (RO): [15:0] event count, [31:16] timeout count.
REQ-016 Unused readdata bits read 0; readdata is reloaded every cycle from the address-selected register, independent of read, giving one-cycle read latency.
REQ-017 EDGE bits are sticky; writing 1 clears a bit and writing 0 leaves it unchanged; a set event in the same cycle as a W1C clear of that bit leaves the bit set.
REQ-018 Event count increments by 1 for each cycle in which any EDGE bit transitions 0->1, whether or not it is masked, and saturates at 0xFFFF.
REQ-019 Any write to COUNT clears both counters and the STATUS timeout flag; writes to STATUS are ignored.
REQ-020 pending = |(EDGE & MASK).
REQ-021 FSM states: IDLE=0, ACTIVE=1, TIMEOUT=2.
REQ-022 IDLE -> ACTIVE when pending=1; the service timer loads TIMEOUT_CYC-1.
REQ-023 ACTIVE: the timer decrements each cycle; go to IDLE if pending=0; otherwise go to TIMEOUT when the timer is 0 and pending=1.
REQ-024 Entering TIMEOUT sets the timeout flag and increments the timeout count, saturating at 0xFFFF.
REQ-025 TIMEOUT -> IDLE when pending=0; if pending=0 and the timer hits 0 in the same cycle, the FSM goes to IDLE and the timeout is not counted.
REQ-026 irq = 1 in ACTIVE and TIMEOUT, registered from the next state, so irq rises the cycle after pending rises and falls the cycle after pending clears.
REQ-027 A MASK write that clears all pending bits deasserts irq via the same path as a W1C clear.

Reset
REQ-028 Asserting reset_n low asynchronously clears all sync flops, edge-delay flops, EDGE, MASK, both counters, the timeout flag, the timer, readdata and irq to 0, and forces the FSM to IDLE.
REQ-029 Edge delay flops come out of reset at 0, so an input already high at reset release produces a rise event after the sync latency.
REQ-030 Reset asserted mid-operation, including in ACTIVE or TIMEOUT, abandons the FSM state with no partial count update.

Structure
REQ-031 Package usb_event_pkg holds the register address constants, EDGE/STATUS bit indices, the FSM state enum and its encodings, and the counter width (16).
REQ-032 Sub-module usb_sync_edge (synchronizer plus rise/fall pulse outputs, parameter SYNC_STAGES) is instantiated once per pin.
REQ-033 Target size is 150-300 lines of RTL; there are no memories and no other clock domains.

Verification
REQ-034 Raise in_gpx with MASK=0 -> EDGE=0x1 at cycle SYNC_STAGES+1, COUNT=0x00000001, irq stays 0.
REQ-035 MASK=0x4, pulse in_int high -> irq=1 one cycle after EDGE[2] sets; write EDGE=0x4 -> irq=0 on the following cycle, FSM IDLE.
REQ-036 TIMEOUT_CYC=8, pending left unserviced -> STATUS[2]=1 and COUNT[31:16]=1 after 8 ACTIVE cycles, irq stays 1; W1C -> IDLE.
REQ-037 W1C of EDGE[0] issued in the same cycle a new gpx rise sets it -> EDGE[0] remains 1, COUNT increments.
REQ-038 Drive 70000 gpx toggles -> COUNT[15:0] saturates at 0xFFFF; write COUNT -> 0x00000000 and STATUS[2]=0.
REQ-039 Assert reset_n low while in TIMEOUT -> irq and readdata 0 immediately, all registers 0 after release.

Source files
------------

// File: rtl/usb_event_pkg.sv
// Shared constants for the MAX3421E event controller: register map, bit
// positions, FSM state encoding and counter width.
package usb_event_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_EDGE   = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int unsigned EDGE_GPX_RISE = 0;
    localparam int unsigned EDGE_GPX_FALL = 1;
    localparam int unsigned EDGE_INT_RISE = 2;
    localparam int unsigned EDGE_W        = 3;

    localparam int unsigned STAT_GPX      = 0;
    localparam int unsigned STAT_INT      = 1;
    localparam int unsigned STAT_TIMEOUT  = 2;
    localparam int unsigned STAT_STATE_LO = 3;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_TIMEOUT = 2'd2
    } fsm_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/usb_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses taken from the last stage against a delayed copy.
module usb_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/usb_event_ctrl.sv
// MAX3421E GPX/INT event controller: sticky edge flags, event/timeout
// counters, a service-timeout FSM and a level irq behind an Avalon-MM slave.
module usb_event_ctrl
    import usb_event_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_gpx,
    input  logic        in_int,
    output logic        irq
);

    localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic gpx_level, gpx_rise, gpx_fall;
    logic int_level, int_rise;

    logic              wr_en;
    logic [EDGE_W-1:0] edge_q, mask_q;
    logic [EDGE_W-1:0] edge_set, edge_clr, edge_next;
    logic              evt_hit, pending;
    logic [CNT_W-1:0]  evt_cnt, tmo_cnt, timer_q, timer_d;
    logic              tmo_flag, tmo_enter;
    fsm_state_t        state_q, state_d;
    logic [31:0]       rd_mux;

    usb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_gpx (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_gpx),
        .level   (gpx_level),
        .rise    (gpx_rise),
        .fall    (gpx_fall)
    );

    usb_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_int (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (in_int),
        .level   (int_level),
        .rise    (int_rise),
        .fall    ()
    );

    assign wr_en = chipselect & write;

    always_comb begin
        edge_set                = '0;
        edge_set[EDGE_GPX_RISE] = gpx_rise;
        edge_set[EDGE_GPX_FALL] = gpx_fall;
        edge_set[EDGE_INT_RISE] = int_rise;
        edge_clr  = (wr_en && address == ADDR_EDGE) ? writedata[EDGE_W-1:0] : '0;
        // a new event wins over a simultaneous W1C of the same bit
        edge_next = (edge_q & ~edge_clr) | edge_set;
        evt_hit   = |(edge_next & ~edge_q);
        pending   = |(edge_q & mask_q);
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tmo_enter = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_ACTIVE;
                    timer_d = TIMER_LOAD;
                end
            end
            ST_ACTIVE: begin
                if (!pending) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d   = ST_TIMEOUT;
                    tmo_enter = 1'b1;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (!pending) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            irq     <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_q <= '0;
            mask_q <= '0;
        end else begin
            edge_q <= edge_next;
            if (wr_en && address == ADDR_MASK) mask_q <= writedata[EDGE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_cnt  <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else if (wr_en && address == ADDR_COUNT) begin
            evt_cnt  <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (evt_hit) evt_cnt <= sat_inc(evt_cnt);
            if (tmo_enter) begin
                tmo_cnt  <= sat_inc(tmo_cnt);
                tmo_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[STAT_GPX]             = gpx_level;
                rd_mux[STAT_INT]             = int_level;
                rd_mux[STAT_TIMEOUT]         = tmo_flag;
                rd_mux[STAT_STATE_LO +: 2]   = state_q;
            end
            ADDR_EDGE:  rd_mux[EDGE_W-1:0] = edge_q;
            ADDR_MASK:  rd_mux[EDGE_W-1:0] = mask_q;
            ADDR_COUNT: rd_mux             = {tmo_cnt, evt_cnt};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_usb_event_ctrl.sv
// Directed and randomized checks of usb_event_ctrl against a cycle-level
// behavioural model built from pin history and pending run length.
module tb_usb_event_ctrl;

    localparam int unsigned S = 2;
    localparam int unsigned T = 8;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write      = 1'b0;
    logic [31:0] writedata  = '0;
    logic [31:0] readdata;
    logic        in_gpx     = 1'b0;
    logic        in_int     = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    usb_event_ctrl #(.SYNC_STAGES(S), .TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_gpx     (in_gpx),
        .in_int     (in_int),
        .irq        (irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          chk_en   = 1'b1;

    // pin history, index 0 = value sampled at the most recent edge
    bit [S:0]    gq, iq;
    logic [2:0]  m_edge, m_mask;
    logic [15:0] m_evt, m_tmo;
    logic        m_flag, m_irq;
    int unsigned m_state, m_run;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        gq = '0; iq = '0;
        m_edge = '0; m_mask = '0; m_evt = '0; m_tmo = '0;
        m_flag = 1'b0; m_irq = 1'b0; m_state = 0; m_run = 0; m_rd = '0;
    endtask

    task automatic model_step();
        logic       pend, wr;
        logic [2:0] set, clr, nxt;
        pend = |(m_edge & m_mask);
        wr   = chipselect && write;
        case (address)
            2'd0:    m_rd = {27'd0, 2'(m_state), m_flag, iq[S-1], gq[S-1]};
            2'd1:    m_rd = {29'd0, m_edge};
            2'd2:    m_rd = {29'd0, m_mask};
            default: m_rd = {m_tmo, m_evt};
        endcase
        set = {iq[S-1] & ~iq[S], ~gq[S-1] & gq[S], gq[S-1] & ~gq[S]};
        clr = (wr && address == 2'd1) ? writedata[2:0] : 3'd0;
        nxt = (m_edge & ~clr) | set;
        if (!pend) m_run = 0;
        else if (m_run < T + 2) m_run++;
        m_state = !pend ? 0 : (m_run <= T ? 1 : 2);
        if (wr && address == 2'd3) begin
            m_evt = '0; m_tmo = '0; m_flag = 1'b0;
        end else begin
            if (|(nxt & ~m_edge) && m_evt != 16'hFFFF) m_evt++;
            if (pend && m_run == T + 1) begin
                m_flag = 1'b1;
                if (m_tmo != 16'hFFFF) m_tmo++;
            end
        end
        m_edge = nxt;
        if (wr && address == 2'd2) m_mask = writedata[2:0];
        m_irq = (m_state != 0);
        gq = {gq[S-1:0], in_gpx};
        iq = {iq[S-1:0], in_int};
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        if (chk_en) begin
            check("irq_cycle", 32'(irq), 32'(m_irq));
            check("readdata_cycle", readdata, m_rd);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write = 1'b1; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // gpx rise with nothing masked: EDGE set at edge S+1, counted, no irq
        address = 2'd1;
        in_gpx  = 1'b1;
        repeat (S + 1) tick();
        check("edge_before_latency", readdata, 32'h0);
        tick();
        check("edge_gpx_rise", readdata, 32'h1);
        address = 2'd3;
        tick();
        check("count_one_event", readdata, 32'h1);
        check("irq_masked_off", 32'(irq), 32'h0);

        // masked int rise raises irq one cycle after EDGE[2]; W1C drops it
        bus_write(2'd2, 32'h4);
        address = 2'd1;
        in_int  = 1'b1;
        repeat (S + 1) tick();
        check("irq_not_yet", 32'(irq), 32'h0);
        tick();
        check("irq_rise", 32'(irq), 32'h1);
        check("edge_gpx_int", readdata, 32'h5);
        in_int = 1'b0;
        bus_write(2'd1, 32'h4);
        check("irq_hold_on_w1c", 32'(irq), 32'h1);
        tick();
        check("irq_fall", 32'(irq), 32'h0);
        address = 2'd0;
        tick();
        check("state_idle", 32'(readdata[4:3]), 32'h0);

        // unserviced pending: TIMEOUT after T ACTIVE cycles
        repeat (4) tick();
        in_int = 1'b1;
        repeat (S + 2 + T) tick();
        check("status_last_active", readdata, 32'h0B);
        tick();
        check("status_timeout", readdata, 32'h17);
        check("irq_in_timeout", 32'(irq), 32'h1);
        address = 2'd3;
        tick();
        check("count_after_timeout", readdata, 32'h0001_0003);
        bus_write(2'd1, 32'h4);
        tick();
        check("irq_after_timeout_w1c", 32'(irq), 32'h0);
        in_int = 1'b0;

        // W1C of EDGE[0] coinciding with a new gpx rise
        bus_write(2'd1, 32'h1);
        in_gpx = 1'b0;
        repeat (S + 3) tick();
        in_gpx = 1'b1;
        repeat (S) tick();
        bus_write(2'd1, 32'h1);
        tick();
        check("edge_set_beats_clear", readdata, 32'h3);
        address = 2'd3;
        tick();
        check("count_set_vs_clear", readdata, 32'h0001_0005);

        // event counter saturation, then clear via COUNT write
        chk_en = 1'b0;
        address = 2'd1; chipselect = 1'b1; write = 1'b1; writedata = 32'h3;
        for (int i = 0; i < 70000; i++) begin
            in_gpx = ~in_gpx;
            tick();
        end
        chipselect = 1'b0; write = 1'b0;
        repeat (S + 3) tick();
        chk_en = 1'b1;
        address = 2'd3;
        tick();
        check("count_saturated", 32'(readdata[15:0]), 32'hFFFF);
        bus_write(2'd3, 32'h0);
        tick();
        check("count_cleared", readdata, 32'h0);
        address = 2'd0;
        tick();
        check("timeout_flag_cleared", 32'(readdata[2]), 32'h0);

        // reset while in TIMEOUT, gpx held high across release
        bus_write(2'd1, 32'h7);
        in_int = 1'b1;
        address = 2'd0;
        repeat (S + 4 + T) tick();
        check("pre_reset_timeout", 32'(readdata[4:3]), 32'h2);
        reset_n = 1'b0;
        model_reset();
        in_gpx = 1'b1;
        in_int = 1'b0;
        #1;
        check("async_reset_irq", 32'(irq), 32'h0);
        check("async_reset_readdata", readdata, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        address = 2'd0; tick();
        check("post_reset_status", readdata, 32'h0);
        address = 2'd1; tick();
        check("post_reset_edge", readdata, 32'h0);
        address = 2'd2; tick();
        check("post_reset_mask", readdata, 32'h0);
        address = 2'd3; tick();
        check("post_reset_count", readdata, 32'h1);
        address = 2'd1; tick();
        check("post_reset_rise", readdata, 32'h1);

        // random pins and bus traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) in_gpx = ~in_gpx;
            if ($urandom_range(5) == 0) in_int = ~in_int;
            address    = 2'($urandom_range(3));
            writedata  = $urandom;
            write      = ($urandom_range(3) == 0) && (address != 2'd3 || $urandom_range(15) == 0);
            chipselect = ($urandom_range(4) != 0);
            tick();
        end
        chipselect = 1'b0; write = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
